// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART command controller.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WR    = 8'h57;
  localparam logic [7:0] OP_RD    = 8'h52;
  localparam logic [7:0] CODE_ACK = 8'h06;
  localparam logic [7:0] CODE_NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, MEM_REQ, MEM_WAIT, TX_LOAD, TX_WAIT
  } state_t;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WR) || (b == OP_RD);
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte idle counter: expire fires once CYCLES idle clocks have elapsed
// since the last reload while enabled.
module uart_cmd_timeout
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  input  logic reload,
  output logic expire
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  assign expire = enable && (cnt == CW'(CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clear || reload)    cnt <= '0;
    else if (enable && !expire)  cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command frame decoder: 'W'/'R' frames become memory requests and the
// result (ACK, NAK or read data) is queued back to the transmitter.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_en,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_wen,
  input  logic              i_tx_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_mem_req,
  output logic              o_mem_we,
  input  logic              i_mem_ready,
  input  logic [31:0]       i_mem_rdata,
  input  logic              i_mem_rvalid,
  output logic              o_busy,
  output logic              o_err
);

  state_t          state, state_nxt;
  logic [1:0]      bcnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]     wdata_q;
  logic            we_q, err_q, err_nxt, tx_first;
  logic [3:0][7:0] tx_q;
  logic [2:0]      tx_cnt;
  logic            in_field, rx_take, expire;

  assign in_field = (state == ADDR) || (state == WDATA);
  assign rx_take  = i_rx_en && ((state == IDLE) || in_field);

  uart_cmd_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk    (clk),
    .rst_n  (i_rst_n),
    .clear  (!in_field),
    .enable (in_field),
    .reload (rx_take),
    .expire (expire)
  );

  assign o_tx_data   = tx_q[0];
  assign o_tx_wen    = (state == TX_LOAD) && i_tx_ready;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_we    = we_q;
  assign o_mem_req   = (state == MEM_REQ);
  assign o_busy      = (state != IDLE);
  assign o_err       = err_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    case (state)
      IDLE:
        if (i_rx_en) begin
          if (is_opcode(i_rx_data)) state_nxt = ADDR;
          else begin
            err_nxt   = 1'b1;
            state_nxt = TX_LOAD;
          end
        end
      ADDR:
        // expiry wins over a byte landing in the same cycle
        if (expire) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (i_rx_en && bcnt == 2'd3) begin
          state_nxt = we_q ? WDATA : MEM_REQ;
        end
      WDATA:
        if (expire) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else if (i_rx_en && bcnt == 2'd3) begin
          state_nxt = MEM_REQ;
        end
      MEM_REQ:
        if (i_mem_ready) state_nxt = we_q ? TX_LOAD : MEM_WAIT;
      MEM_WAIT:
        if (i_mem_rvalid) state_nxt = TX_LOAD;
      TX_LOAD:
        if (i_tx_ready) state_nxt = TX_WAIT;
      TX_WAIT:
        // the transmitter's ready lags the strobe by a cycle, so skip it once
        if (!tx_first && i_tx_ready) state_nxt = (tx_cnt != 3'd0) ? TX_LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bcnt     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      tx_first <= 1'b0;
      tx_q     <= '0;
      tx_cnt   <= '0;
    end else begin
      err_q    <= err_nxt;
      tx_first <= (state == TX_LOAD) && i_tx_ready;
      case (state)
        IDLE: begin
          bcnt <= '0;
          if (i_rx_en) begin
            if (is_opcode(i_rx_data)) begin
              we_q <= (i_rx_data == OP_WR);
            end else begin
              tx_q   <= {24'h0, CODE_NAK};
              tx_cnt <= 3'd1;
            end
          end
        end
        ADDR:
          if (i_rx_en && !expire) begin
            // bytes beyond ADDR_W fall outside the loop and are dropped
            for (int i = 0; i < int'(ADDR_W); i++)
              if (bcnt == 2'(i / 8)) addr_q[i] <= i_rx_data[3'(i % 8)];
            bcnt <= bcnt + 2'd1;
          end
        WDATA:
          if (i_rx_en && !expire) begin
            wdata_q <= {i_rx_data, wdata_q[31:8]};
            bcnt    <= bcnt + 2'd1;
          end
        MEM_REQ:
          if (i_mem_ready && we_q) begin
            tx_q   <= {24'h0, CODE_ACK};
            tx_cnt <= 3'd1;
          end
        MEM_WAIT:
          if (i_mem_rvalid) begin
            tx_q   <= i_mem_rdata;
            tx_cnt <= 3'd4;
          end
        TX_LOAD:
          if (i_tx_ready) begin
            tx_q   <= {8'h00, tx_q[3:1]};
            tx_cnt <= tx_cnt - 3'd1;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: frame table plus timeout and reset sequences.
module tb_uart_cmd_ctrl;

  localparam int ADDR_W = 16;
  localparam int TO     = 100;
  localparam int RD_DLY = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              i_rst_n;
  logic [7:0]        i_rx_data;
  logic              i_rx_en;
  logic [7:0]        o_tx_data;
  logic              o_tx_wen;
  logic              i_tx_ready;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic              o_mem_req;
  logic              o_mem_we;
  logic              i_mem_ready;
  logic [31:0]       i_mem_rdata;
  logic              i_mem_rvalid;
  logic              o_busy;
  logic              o_err;

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_rx_data(i_rx_data), .i_rx_en(i_rx_en),
    .o_tx_data(o_tx_data), .o_tx_wen(o_tx_wen), .i_tx_ready(i_tx_ready),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_req(o_mem_req),
    .o_mem_we(o_mem_we), .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
    .i_mem_rvalid(i_mem_rvalid), .o_busy(o_busy), .o_err(o_err)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]        tx_log[$];
  int                err_cnt;
  int                nreq;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [31:0]       req_wdata;
  bit                unstable;
  logic [31:0]       mem_rdata = 32'h0;
  int                mem_stall = 0;

  typedef struct {
    logic [71:0]       s;
    int                n, gap, stall;
    logic [31:0]       rdata;
    int                junk;
    int                exp_req;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0]       exp_wdata;
    int                exp_ntx;
    logic [31:0]       exp_tx;
    int                exp_err;
  } vec_t;

  function automatic vec_t mkv(logic [71:0] s, int n, int gap, int stall, logic [31:0] rdata,
                               int junk, int er, logic ew, logic [ADDR_W-1:0] ea,
                               logic [31:0] ed, int nt, logic [31:0] et, int ee);
    vec_t v;
    v.s = s; v.n = n; v.gap = gap; v.stall = stall; v.rdata = rdata; v.junk = junk;
    v.exp_req = er; v.exp_we = ew; v.exp_addr = ea; v.exp_wdata = ed;
    v.exp_ntx = nt; v.exp_tx = et; v.exp_err = ee;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    i_rx_data = b;
    i_rx_en   = 1'b1;
    @(negedge clk);
    i_rx_en   = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (o_busy && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({name, " reached idle"}, {31'h0, o_busy}, 32'h0);
    repeat (6) @(negedge clk);
  endtask

  // Transmitter: takes a byte on each strobe, drops ready one cycle later for a while
  initial begin
    int busy;
    bit pend;
    busy = 0; pend = 0; err_cnt = 0; i_tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!i_rst_n) begin
        busy = 0; pend = 0; i_tx_ready = 1'b1;
      end else begin
        if (o_err) err_cnt++;
        if (o_tx_wen) tx_log.push_back(o_tx_data);
        if (pend) begin
          pend = 0; busy = 3; i_tx_ready = 1'b0;
        end else if (busy > 0) begin
          busy--;
          if (busy == 0) i_tx_ready = 1'b1;
        end
        if (o_tx_wen) pend = 1;
      end
    end
  end

  // Memory: stalls mem_stall cycles, returns read data RD_DLY clocks after accept
  initial begin
    int stall, cd;
    logic [ADDR_W-1:0] a0;
    logic [31:0] d0;
    logic w0;
    stall = 0; cd = 0; nreq = 0; unstable = 0;
    a0 = '0; d0 = '0; w0 = 1'b0;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      i_mem_rvalid = 1'b0;
      i_mem_ready  = 1'b0;
      if (!i_rst_n) begin
        stall = 0; cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin i_mem_rvalid = 1'b1; i_mem_rdata = mem_rdata; end
        end
        if (o_mem_req) begin
          if (stall == 0) begin
            a0 = o_mem_addr; d0 = o_mem_wdata; w0 = o_mem_we;
          end else if (o_mem_addr !== a0 || o_mem_wdata !== d0 || o_mem_we !== w0) begin
            unstable = 1;
          end
          if (stall >= mem_stall) begin
            i_mem_ready = 1'b1;
            nreq++;
            req_addr = a0; req_we = w0; req_wdata = d0;
            if (!w0) cd = RD_DLY;
            stall = 0;
          end else begin
            stall++;
          end
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int bt, be, br;
    string nm;
    nm = $sformatf("vec%0d", idx);
    bt = tx_log.size(); be = err_cnt; br = nreq;
    mem_stall = v.stall; mem_rdata = v.rdata; unstable = 0;
    for (int i = 0; i < v.n; i++) send_byte(v.s[71-8*i -: 8], v.gap);
    if (v.junk >= 0) begin
      repeat (2) @(negedge clk);
      send_byte(8'(v.junk), 0);
    end
    wait_idle(nm);
    chk({nm, " requests"}, nreq - br, v.exp_req);
    if (v.exp_req == 1 && nreq - br == 1) begin
      chk({nm, " addr"}, req_addr, v.exp_addr);
      chk({nm, " we"}, {31'h0, req_we}, {31'h0, v.exp_we});
      if (v.exp_we) chk({nm, " wdata"}, req_wdata, v.exp_wdata);
      chk({nm, " req stable"}, {31'h0, unstable}, 32'h0);
    end
    chk({nm, " tx count"}, tx_log.size() - bt, v.exp_ntx);
    for (int j = 0; j < v.exp_ntx; j++)
      if (bt + j < tx_log.size())
        chk($sformatf("%s tx byte %0d", nm, j), tx_log[bt+j], v.exp_tx[31-8*j -: 8]);
    chk({nm, " err pulses"}, err_cnt - be, v.exp_err);
  endtask

  vec_t vecs[7];

  initial begin
    int bt, be, br, first, k;
    vecs[0] = mkv(72'h57_10000000_EFBEADDE,      9, 1, 0,  32'h0,        -1, 1, 1'b1, 16'h0010, 32'hDEADBEEF, 1, 32'h06000000, 0);
    vecs[1] = mkv({40'h52_10000000, 32'h0},      5, 1, 0,  32'h12345678, -1, 1, 1'b0, 16'h0010, 32'h0,        4, 32'h78563412, 0);
    vecs[2] = mkv({8'h41, 64'h0},                1, 0, 0,  32'h0,        -1, 0, 1'b0, 16'h0,    32'h0,        1, 32'h15000000, 1);
    vecs[3] = mkv({40'h52_0400A5A5, 32'h0},      5, 0, 0,  32'hCAFEF00D, 'h41, 1, 1'b0, 16'h0004, 32'h0,      4, 32'h0DF0FECA, 0);
    vecs[4] = mkv(72'h57_00010000_78563412,      9, 0, 20, 32'h0,        -1, 1, 1'b1, 16'h0100, 32'h12345678, 1, 32'h06000000, 0);
    vecs[5] = mkv({8'hFF, 64'h0},                1, 0, 0,  32'h0,        -1, 0, 1'b0, 16'h0,    32'h0,        1, 32'h15000000, 1);
    vecs[6] = mkv(72'h57_FFFF3412_01000080,      9, 2, 3,  32'h0,        -1, 1, 1'b1, 16'hFFFF, 32'h80000001, 1, 32'h06000000, 0);

    i_rst_n = 1'b0; i_rx_en = 1'b0; i_rx_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset tx_wen",  {31'h0, o_tx_wen}, 32'h0);
    chk("reset tx_data", {24'h0, o_tx_data}, 32'h0);
    chk("reset mem_req", {31'h0, o_mem_req}, 32'h0);
    chk("reset mem_addr", {16'h0, o_mem_addr}, 32'h0);
    chk("reset busy",    {31'h0, o_busy}, 32'h0);
    chk("reset err",     {31'h0, o_err}, 32'h0);
    i_rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) run_vec(vecs[v], v);

    // truncated write frame, then silence until the inter-byte timeout
    bt = tx_log.size(); be = err_cnt; br = nreq;
    send_byte(8'h57, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
    first = -1; k = 0;
    while (first < 0 && k < 200) begin
      @(negedge clk);
      k++;
      if (o_err) first = k;
    end
    chk("timeout latency in 100..102", {31'h0, (first >= 100 && first <= 102)}, 32'h1);
    repeat (10) @(negedge clk);
    chk("timeout busy", {31'h0, o_busy}, 32'h0);
    chk("timeout tx count", tx_log.size() - bt, 0);
    chk("timeout requests", nreq - br, 0);
    chk("timeout err pulses", err_cnt - be, 1);
    run_vec(vecs[1], 10);

    // reset in the middle of a four-byte read response
    bt = tx_log.size(); br = nreq;
    mem_rdata = 32'h12345678; mem_stall = 0;
    send_byte(8'h52, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    k = 0;
    while (tx_log.size() - bt < 2 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("mid-response two bytes sent", tx_log.size() - bt, 2);
    @(negedge clk);
    i_rst_n = 1'b0;
    #1;
    chk("abort tx_wen",   {31'h0, o_tx_wen}, 32'h0);
    chk("abort busy",     {31'h0, o_busy}, 32'h0);
    chk("abort tx_data",  {24'h0, o_tx_data}, 32'h0);
    chk("abort mem_we",   {31'h0, o_mem_we}, 32'h0);
    chk("abort mem_wdata", o_mem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    be = err_cnt;
    send_byte(8'h41, 0);
    wait_idle("post-reset");
    repeat (30) @(negedge clk);
    chk("post-reset tx count", tx_log.size() - bt, 3);
    if (tx_log.size() - bt == 3) chk("post-reset nak", tx_log[bt+2], 8'h15);
    chk("post-reset requests", nreq - br, 1);
    chk("post-reset err pulses", err_cnt - be, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
